t_pulse_gen: RTL and testbench



---
 rtl/t_pulse_gen.sv | 170 +++++++++++++++++
 tb/tb_t_pulse_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/t_pulse_gen.sv
// -----------------------------------------------------------------------------
// t_pulse_gen
//   Front end for a T flip-flop. It takes a raw, bouncy, asynchronous level
//   (push-button or external strobe), synchronises it into clk and debounces
//   it. For every accepted rising transition it emits exactly one single-cycle
//   toggle pulse, which drives the flip-flop's t input directly. It also keeps
//   a wrapping count of the pulses it has issued, for debug.
//
// Optional feature (compile-time macro): T_PULSE_FALL_EDGE_EN
//   When this macro is defined, an accepted falling transition also pulses
//   t_out and increments pulse_cnt, so downstream q follows the button level.
//   When it is undefined, only rising transitions pulse. A falling acceptance
//   then updates stable_level only.
//
// Parameters
//   DEBOUNCE_CYCLES : number of further synchronised cycles a new level must
//                     hold after it is first seen (legal range 1..65535)
//   PCNT_W          : width of pulse_cnt
//
// Ports
//   clk          in   rising-edge system clock
//   rstn         in   asynchronous active-low reset
//   btn_in       in   raw asynchronous level; may glitch or bounce
//   t_out        out  registered single-cycle toggle pulse
//   stable_level out  registered debounced level
//   pulse_cnt    out  number of t_out pulses issued, modulo 2^PCNT_W
// -----------------------------------------------------------------------------
module t_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned PCNT_W          = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              btn_in,
   output logic              t_out,
   output logic              stable_level,
   output logic [PCNT_W-1:0] pulse_cnt
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [PCNT_W-1:0] PCNT_ZERO = {PCNT_W{1'b0}};
   localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

   typedef enum logic [1:0] {
      LOW_STABLE  = 2'd0,
      CHK_HIGH    = 2'd1,
      HIGH_STABLE = 2'd2,
      CHK_LOW     = 2'd3
   } state_e;

   logic              s1_q;
   logic              s2_q;
   state_e            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              stable_q, stable_d;
   logic              t_q,      t_d;
   logic [PCNT_W-1:0] pcnt_q,   pcnt_d;

   // Two-flop synchroniser. Only s2_q is used downstream.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn_in;
         s2_q <= s1_q;
      end
   end

   // Debounce FSM state, counter and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= LOW_STABLE;
         cnt_q    <= CNT_ZERO;
         stable_q <= 1'b0;
         t_q      <= 1'b0;
         pcnt_q   <= PCNT_ZERO;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         t_q      <= t_d;
         pcnt_q   <= pcnt_d;
      end
   end

   // Next-state logic. t_d defaults to 0, so a pulse lasts exactly one cycle:
   // an acceptance always leaves a CHK_* state, and a stable state never
   // accepts on the next edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      t_d      = 1'b0;
      pcnt_d   = pcnt_q;

      case (state_q)
         LOW_STABLE: begin
            stable_d = 1'b0;
            if (s2_q) begin
               state_d = CHK_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end

         CHK_HIGH: begin
            if (!s2_q) begin
               // A reversal discards the partial count; no hysteresis.
               state_d = LOW_STABLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = HIGH_STABLE;
               cnt_d    = CNT_ZERO;
               stable_d = 1'b1;
               t_d      = 1'b1;
               pcnt_d   = pcnt_q + PCNT_ONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         HIGH_STABLE: begin
            stable_d = 1'b1;
            if (!s2_q) begin
               state_d = CHK_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end

         CHK_LOW: begin
            if (s2_q) begin
               state_d = HIGH_STABLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = LOW_STABLE;
               cnt_d    = CNT_ZERO;
               stable_d = 1'b0;
`ifdef T_PULSE_FALL_EDGE_EN
               t_d      = 1'b1;
               pcnt_d   = pcnt_q + PCNT_ONE;
`else
               t_d      = 1'b0;
               pcnt_d   = pcnt_q;
`endif
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d  = LOW_STABLE;
            cnt_d    = CNT_ZERO;
            stable_d = 1'b0;
         end
      endcase
   end

   assign t_out        = t_q;
   assign stable_level = stable_q;
   assign pulse_cnt    = pcnt_q;

endmodule

// File: tb/tb_t_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_t_pulse_gen
//   Self-checking bench for t_pulse_gen (DEBOUNCE_CYCLES=4, PCNT_W=2).
//   The reference model works on run lengths. It delays btn_in by two edges
//   to form the synchronised sample. It then counts how many consecutive
//   samples differ from the accepted level. When that count reaches
//   DEBOUNCE_CYCLES+1, the new level is accepted.
//   Honours T_PULSE_FALL_EDGE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_t_pulse_gen;

   localparam int D  = 4;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          btn_in = 1'b0;
   logic          t_out;
   logic          stable_level;
   logic [PW-1:0] pulse_cnt;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic m_d1, m_d2, m_stable, m_t, prev_t;
   int   m_run, m_pulses;

   t_pulse_gen #(.DEBOUNCE_CYCLES(D), .PCNT_W(PW)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .btn_in       (btn_in),
      .t_out        (t_out),
      .stable_level (stable_level),
      .pulse_cnt    (pulse_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_d1 = 1'b0; m_d2 = 1'b0; m_stable = 1'b0; m_t = 1'b0;
      m_run = 0; m_pulses = 0; prev_t = 1'b0;
   endtask

   // One clock edge of the reference model; b is the btn_in level before the edge.
   task automatic model_edge(input logic b);
      logic seen;
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = b;
      m_t  = 1'b0;
      if (seen != m_stable) begin
         m_run++;
         if (m_run == D + 1) begin
            m_run = 0;
            if (!m_stable) begin
               m_t = 1'b1;
               m_pulses++;
            end else begin
`ifdef T_PULSE_FALL_EDGE_EN
               m_t = 1'b1;
               m_pulses++;
`endif
            end
            m_stable = ~m_stable;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic compare_model(input string tag);
      check_val({tag, ".t_out"}, 32'(t_out), 32'(m_t));
      check_val({tag, ".stable"}, 32'(stable_level), 32'(m_stable));
      check_val({tag, ".pcnt"}, 32'(pulse_cnt), 32'(m_pulses % (1 << PW)));
      check_val({tag, ".t_width"}, 32'(t_out & prev_t), 32'd0);
      prev_t = t_out;
   endtask

   task automatic step(input logic b, input string tag);
      btn_in = b;
      @(posedge clk);
      model_edge(b);
      #1;
      compare_model(tag);
   endtask

   task automatic apply_reset(input int cycles, input logic b);
      @(negedge clk);
      btn_in = b;
      rstn   = 1'b0;
      #1;
      model_clear();
      compare_model("rst");
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         compare_model("rst_hold");
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      int lvl_i, len, seg_cnt;
      model_clear();

      // reset state
      apply_reset(2, 1'b0);
      check_val("rst_t", 32'(t_out), 32'd0);
      check_val("rst_stable", 32'(stable_level), 32'd0);
      check_val("rst_pcnt", 32'(pulse_cnt), 32'd0);

      // clean press: pulse only after edge D+2
      for (int i = 0; i < 10; i++) begin
         step(1'b1, "press");
         check_val("press_t", 32'(t_out), 32'(i == D + 2));
         check_val("press_stable", 32'(stable_level), 32'(i >= D + 2));
      end
      check_val("press_pcnt", 32'(pulse_cnt), 32'd1);

      // release: level drops after edge D+2
      for (int i = 0; i < 10; i++) begin
         step(1'b0, "release");
         check_val("release_stable", 32'(stable_level), 32'(i < D + 2));
`ifdef T_PULSE_FALL_EDGE_EN
         check_val("release_t", 32'(t_out), 32'(i == D + 2));
`else
         check_val("release_t", 32'(t_out), 32'd0);
`endif
      end
`ifdef T_PULSE_FALL_EDGE_EN
      check_val("release_pcnt", 32'(pulse_cnt), 32'd2);
`else
      check_val("release_pcnt", 32'(pulse_cnt), 32'd1);
`endif

      // glitch: high for 3 cycles is rejected
      apply_reset(1, 1'b0);
      for (int i = 0; i < 13; i++) begin
         step((i < 3) ? 1'b1 : 1'b0, "glitch");
         check_val("glitch_t", 32'(t_out), 32'd0);
         check_val("glitch_stable", 32'(stable_level), 32'd0);
      end
      check_val("glitch_pcnt", 32'(pulse_cnt), 32'd0);

      // bounce: toggle for 10 cycles, then hold high
      apply_reset(1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step((i % 2 == 0) ? 1'b1 : 1'b0, "bounce");
         check_val("bounce_t", 32'(t_out), 32'd0);
      end
      for (int j = 0; j < 12; j++) begin
         step(1'b1, "bounce_hold");
         check_val("bounce_hold_t", 32'(t_out), 32'(j == D + 2));
      end
      check_val("bounce_pcnt", 32'(pulse_cnt), 32'd1);

      // counter wrap with PCNT_W=2: expected sequence 1,2,3,0,1
      apply_reset(1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 8; i++) step(1'b1, "wrap_hi");
`ifdef T_PULSE_FALL_EDGE_EN
         check_val("wrap_pcnt", 32'(pulse_cnt), 32'((2 * k + 1) % 4));
`else
         check_val("wrap_pcnt", 32'(pulse_cnt), 32'((k + 1) % 4));
`endif
         for (int i = 0; i < 8; i++) step(1'b0, "wrap_lo");
      end

      // btn_in high at reset release counts as a new rising edge
      apply_reset(2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, "rel_high");
         check_val("rel_high_t", 32'(t_out), 32'(i == D + 2));
      end

      // reset asserted mid-CHK_HIGH: cleared at once, no pulse afterwards
      apply_reset(1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, "midchk");
      #2;
      rstn = 1'b0;
      #1;
      model_clear();
      check_val("midrst_t", 32'(t_out), 32'd0);
      check_val("midrst_stable", 32'(stable_level), 32'd0);
      check_val("midrst_pcnt", 32'(pulse_cnt), 32'd0);
      btn_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, "post_rst");
         check_val("post_rst_t", 32'(t_out), 32'd0);
         check_val("post_rst_pcnt", 32'(pulse_cnt), 32'd0);
      end

      // randomized segments of holds and glitches, with occasional resets
      seg_cnt = 0;
      while (seg_cnt < 400) begin
         lvl_i = $urandom_range(1, 0);
         if ($urandom_range(3, 0) == 0) len = $urandom_range(2 * D + 6, D + 2);
         else len = $urandom_range(D + 1, 1);
         for (int i = 0; i < len; i++) step(lvl_i[0], "rand");
         if ($urandom_range(39, 0) == 0) apply_reset($urandom_range(2, 1), lvl_i[0]);
         seg_cnt++;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
